cut_response_misr: RTL and testbench
====================================

Name: cut_response_misr

Overview:
- Response-side harness block for combinational benchmark circuits (CUTs) in the dataset flow.
- Accepts a stream of CUT output vectors, default 26 bits (f1..f26), over a valid/ready handshake.
- Compacts the vectors into a multiple-input signature register (MISR), counts accepted vectors and compares the final signature against an expected golden value.
- Sits between the CUT output bus and the test controller; it is the reader for the stimulus writer that drives the CUT inputs.

Parameters:
- OUT_W, 26, width of the CUT response vector and of the signature.
- CNT_W, 16, width of the vector counter and of num_vectors.
- POLY, 26'h0000047, MISR feedback mask (x^26+x^6+x^2+x+1). Bit i set means bit i is XORed with the shifted-out MSB.
- SEED, 26'h0000000, signature value loaded at start.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin a run; sampled in IDLE or DONE only.
- clear  in  1  synchronous abort; returns the block to IDLE.
- num_vectors  in  CNT_W  number of responses to compact; latched on start.
- expected_sig  in  OUT_W  golden signature; sampled on the DONE entry cycle.
- resp_valid  in  1  response vector valid.
- resp_data  in  OUT_W  CUT response vector.
- resp_ready  out  1  block can accept a response.
- busy  out  1  high in RUN.
- done  out  1  high in DONE (level, held).
- pass  out  1  signature matched expected_sig; meaningful only while done=1.
- signature  out  OUT_W  current MISR contents.
- count  out  CNT_W  number of responses accepted in the current run.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, signature=SEED, count=0, resp_ready=0, busy=0, done=0, pass=0.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1:
  - load signature=SEED, count=0, latch num_vectors into target.
  - next state RUN if num_vectors!=0.
  - next state DONE if num_vectors==0; pass=(SEED==expected_sig).
- RUN:
  - resp_ready=1 and busy=1; resp_ready is a registered function of state.
  - A transfer occurs when resp_valid & resp_ready.
  - On a transfer:
    - signature <= {signature[OUT_W-2:0],1'b0} ^ (signature[OUT_W-1] ? POLY : 0) ^ resp_data.
    - count <= count+1.
  - If the transfer is the target-th, the next state is DONE.
  - resp_ready deasserts in the cycle after the last transfer.
  - resp_valid=0: signature and count hold; a stalled upstream has no timeout.
- DONE entry (same edge as the last transfer):
  - pass <= (next signature == expected_sig).
  - done=1 from the following cycle.
- DONE:
  - signature, count and pass hold.
  - start=1 restarts exactly as from IDLE.
  - resp_ready=0; responses are ignored.
- start while in RUN: ignored; num_vectors is not re-latched.
- clear=1, any state: next state IDLE, done=0, pass=0, busy=0. signature and count hold their last values for debug. clear has priority over start and over a transfer in the same cycle.
- Arithmetic rules:
  - count wraps modulo 2^CNT_W; it cannot wrap within a run because target ≤ 2^CNT_W-1.
  - All vectors use unsigned bit-wise XOR only.
- rst_n asserted mid-run: immediate return to reset values; the in-flight response is dropped.
- Latency:
  - one cycle from start to resp_ready=1.
  - one cycle from the last transfer to done=1.

Decomposition:
- Shared package cut_harness_pkg:
  - state enum (IDLE, RUN, DONE).
  - default OUT_W, CNT_W, POLY and SEED constants, shared with the stimulus LFSR generator.
- One natural sub-module, misr_step: purely combinational next-signature function (signature, resp_data, POLY -> next). It is reused by the stimulus side and by a bench reference model.

Test Plan:
- Reset mid-run: start, num_vectors=3, two transfers, pulse rst_n low → all outputs at reset values immediately; count=0, signature=0.
- Basic compaction: start, num_vectors=2, responses 26'h0000001 then 26'h0000002, expected_sig=0 → signature 26'h0000001 then 26'h0000000; done=1; pass=1; count=2.
- Feedback path: num_vectors=2, responses 26'h2000000 then 26'h0000000, expected_sig=26'h0000047 → pass=1.
  - Repeat with expected_sig=26'h0000046 → pass=0.
- Backpressure and idle gaps: num_vectors=4, resp_valid toggled randomly, start pulsed during RUN → exactly 4 transfers counted; start has no effect; resp_ready=0 after the 4th transfer.
- Zero-length and restart: num_vectors=0, expected_sig=0 → DONE in one cycle with pass=1. Then start with num_vectors=1, response 26'h3FFFFFF, expected 26'h3FFFFFF → pass=1.
- Clear priority: clear and resp_valid high together in RUN → no count increment; state IDLE; done=0.

Source files
------------

// File: rtl/cut_harness_pkg.sv
// Shared definitions for the CUT test harness: FSM state encoding and the
// default MISR geometry used by both the response compactor and the stimulus
// LFSR generator.
package cut_harness_pkg;

    localparam int          DEF_OUT_W = 26;
    localparam int          DEF_CNT_W = 16;
    localparam logic [25:0] DEF_POLY  = 26'h0000047;  // x^26+x^6+x^2+x+1
    localparam logic [25:0] DEF_SEED  = 26'h0000000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/misr_step.sv
// One MISR clock step as pure combinational logic: shift left, fold the
// shifted-out MSB back through the feedback mask, then XOR in the response.
module misr_step #(
    parameter int               OUT_W = 26,
    parameter logic [OUT_W-1:0] POLY  = 26'h0000047
) (
    input  logic [OUT_W-1:0] sig,
    input  logic [OUT_W-1:0] data,
    output logic [OUT_W-1:0] next
);

    // Next signature from current signature and incoming response vector.
    always_comb begin
        next = {sig[OUT_W-2:0], 1'b0} ^ (sig[OUT_W-1] ? POLY : '0) ^ data;
    end

endmodule

// File: rtl/cut_response_misr.sv
// Response-side harness: accepts CUT output vectors over valid/ready,
// compacts them into a MISR, counts them, and compares the final signature
// against a golden value.
module cut_response_misr
    import cut_harness_pkg::*;
#(
    parameter int               OUT_W = DEF_OUT_W,
    parameter int               CNT_W = DEF_CNT_W,
    parameter logic [OUT_W-1:0] POLY  = DEF_POLY,
    parameter logic [OUT_W-1:0] SEED  = DEF_SEED
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clear,
    input  logic [CNT_W-1:0] num_vectors,
    input  logic [OUT_W-1:0] expected_sig,
    input  logic             resp_valid,
    input  logic [OUT_W-1:0] resp_data,
    output logic             resp_ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [OUT_W-1:0] signature,
    output logic [CNT_W-1:0] count
);

    state_t           state;
    state_t           next_state;
    logic             load;
    logic             xfer;
    logic             last;
    logic [CNT_W-1:0] target;
    logic [OUT_W-1:0] sig_next;

    misr_step #(
        .OUT_W (OUT_W),
        .POLY  (POLY)
    ) u_misr_step (
        .sig  (signature),
        .data (resp_data),
        .next (sig_next)
    );

    // resp_ready is only ever high in RUN, so a transfer implies RUN.
    assign xfer = resp_valid & resp_ready;
    assign last = (count + CNT_W'(1)) == target;

    // Next-state decode; clear overrides both start and a final transfer.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned, which would infer a latch.
        next_state = state;
        load       = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    load       = 1'b1;
                    next_state = (num_vectors == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (xfer && last) begin
                    next_state = DONE;
                end
            end
            default: next_state = IDLE;
        endcase
        if (clear) begin
            next_state = IDLE;
            load       = 1'b0;
        end
    end

    // State and the status flags, registered straight from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            resp_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge values, independent of statement order.
            state      <= next_state;
            resp_ready <= (next_state == RUN);
            busy       <= (next_state == RUN);
            done       <= (next_state == DONE);
        end
    end

    // Signature, counter, run length and verdict; these hold across clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            signature <= SEED;
            count     <= '0;
            target    <= '0;
            pass      <= 1'b0;
        end else if (clear) begin
            pass <= 1'b0;
        end else if (load) begin
            signature <= SEED;
            count     <= '0;
            target    <= num_vectors;
            pass      <= (num_vectors == '0) && (SEED == expected_sig);
        end else if (xfer) begin
            signature <= sig_next;
            count     <= count + CNT_W'(1);
            if (last) begin
                pass <= (sig_next == expected_sig);
            end
        end
    end

endmodule

// File: tb/tb_cut_response_misr.sv
// Self-checking bench for cut_response_misr: directed scenarios plus random
// runs, compared against a polynomial-arithmetic signature model.
module tb_cut_response_misr;

    localparam int OUT_W = 26;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             clear;
    logic [CNT_W-1:0] num_vectors;
    logic [OUT_W-1:0] expected_sig;
    logic             resp_valid;
    logic [OUT_W-1:0] resp_data;
    logic             resp_ready;
    logic             busy;
    logic             done;
    logic             pass;
    logic [OUT_W-1:0] signature;
    logic [CNT_W-1:0] count;

    int n_vec;
    int n_err;

    cut_response_misr dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .clear        (clear),
        .num_vectors  (num_vectors),
        .expected_sig (expected_sig),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data),
        .resp_ready   (resp_ready),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .signature    (signature),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Signature model: multiply the running polynomial by x, reduce modulo
    // P(x) = x^26+x^6+x^2+x+1 over GF(2), then add the new response.
    function automatic logic [OUT_W-1:0] ref_step(input logic [OUT_W-1:0] s,
                                                  input logic [OUT_W-1:0] d);
        logic [63:0] p;
        p = 64'(s) * 64'd2;
        if (p >= 64'h4000000) p = p ^ 64'h4000047;
        return p[OUT_W-1:0] ^ d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic do_start(input int nv, input logic [OUT_W-1:0] exp);
        num_vectors  = CNT_W'(nv);
        expected_sig = exp;
        start        = 1'b1;
        tick();
        start        = 1'b0;
    endtask

    // Offer one response; with 'noisy' set, valid and start are randomly
    // toggled. Returns once the transfer happened or the budget expired.
    task automatic send(input logic [OUT_W-1:0] d, input bit noisy);
        bit accepted;
        accepted  = 1'b0;
        resp_data = d;
        for (int i = 0; i < 60 && !accepted; i++) begin
            resp_valid = noisy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (noisy && $urandom_range(0, 3) == 0) begin
                start       = 1'b1;
                num_vectors = CNT_W'(1);
            end
            accepted = resp_valid && resp_ready;
            tick();
            start = 1'b0;
        end
        resp_valid = 1'b0;
        if (!accepted) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: got no transfer expected transfer within 60 cycles");
        end
    endtask

    task automatic check_idle_outputs(input string name);
        cmp({name, "_ready"}, 32'(resp_ready), 32'd0);
        cmp({name, "_busy"},  32'(busy),       32'd0);
        cmp({name, "_done"},  32'(done),       32'd0);
        cmp({name, "_pass"},  32'(pass),       32'd0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        check_idle_outputs("por");
        cmp("por_sig", 32'(signature), 32'd0);
        cmp("por_cnt", 32'(count), 32'd0);
        rst_n = 1'b1;
        tick();
        do_start(3, '0);
        cmp("rst_ready_latency", 32'(resp_ready), 32'd1);
        send(26'h1234567, 1'b0);
        send(26'h0ABCDEF, 1'b0);
        cmp("rst_cnt_before", 32'(count), 32'd2);
        resp_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check_idle_outputs("midrun_rst");
        cmp("midrun_rst_sig", 32'(signature), 32'd0);
        cmp("midrun_rst_cnt", 32'(count), 32'd0);
        resp_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        do_start(2, '0);
        cmp("basic_busy", 32'(busy), 32'd1);
        send(26'h0000001, 1'b0);
        cmp("basic_sig1", 32'(signature), 32'h0000001);
        cmp("basic_done_early", 32'(done), 32'd0);
        send(26'h0000002, 1'b0);
        cmp("basic_sig2", 32'(signature), 32'h0000000);
        cmp("basic_done", 32'(done), 32'd1);
        cmp("basic_pass", 32'(pass), 32'd1);
        cmp("basic_cnt", 32'(count), 32'd2);
        cmp("basic_ready_off", 32'(resp_ready), 32'd0);
        cmp("basic_busy_off", 32'(busy), 32'd0);
    endtask

    task automatic test_feedback();
        do_start(2, 26'h0000047);
        send(26'h2000000, 1'b0);
        send(26'h0000000, 1'b0);
        cmp("fb_sig", 32'(signature), 32'h0000047);
        cmp("fb_pass", 32'(pass), 32'd1);
        do_start(2, 26'h0000046);
        send(26'h2000000, 1'b0);
        send(26'h0000000, 1'b0);
        cmp("fb_bad_done", 32'(done), 32'd1);
        cmp("fb_bad_pass", 32'(pass), 32'd0);
        // Responses offered in DONE must not be taken.
        resp_valid = 1'b1;
        resp_data  = 26'h1555555;
        repeat (3) tick();
        resp_valid = 1'b0;
        cmp("done_hold_sig", 32'(signature), 32'h0000047);
        cmp("done_hold_cnt", 32'(count), 32'd2);
    endtask

    task automatic test_backpressure();
        logic [OUT_W-1:0] model;
        logic [OUT_W-1:0] d;
        model = '0;
        do_start(4, '0);
        for (int i = 0; i < 4; i++) begin
            d     = OUT_W'($urandom);
            model = ref_step(model, d);
            send(d, 1'b1);
            if (i == 1) cmp("bp_still_busy", 32'(busy), 32'd1);
            // Idle gap with valid low: nothing may move.
            resp_valid = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
        end
        cmp("bp_cnt", 32'(count), 32'd4);
        cmp("bp_sig", 32'(signature), 32'(model));
        cmp("bp_ready_off", 32'(resp_ready), 32'd0);
        cmp("bp_done", 32'(done), 32'd1);
        cmp("bp_pass", 32'(pass), 32'(model == '0));
    endtask

    task automatic test_zero_restart();
        do_start(0, '0);
        cmp("zero_done", 32'(done), 32'd1);
        cmp("zero_pass", 32'(pass), 32'd1);
        cmp("zero_cnt", 32'(count), 32'd0);
        cmp("zero_ready", 32'(resp_ready), 32'd0);
        do_start(1, 26'h3FFFFFF);
        send(26'h3FFFFFF, 1'b0);
        cmp("restart_sig", 32'(signature), 32'h3FFFFFF);
        cmp("restart_pass", 32'(pass), 32'd1);
    endtask

    task automatic test_clear();
        logic [OUT_W-1:0] model;
        model = ref_step('0, 26'h00F00F0);
        do_start(3, '0);
        send(26'h00F00F0, 1'b0);
        clear      = 1'b1;
        resp_valid = 1'b1;
        resp_data  = 26'h0000003;
        tick();
        clear      = 1'b0;
        resp_valid = 1'b0;
        check_idle_outputs("clr");
        cmp("clr_cnt_hold", 32'(count), 32'd1);
        cmp("clr_sig_hold", 32'(signature), 32'(model));
        // Clear wins over start too, and wipes a held verdict in DONE.
        do_start(0, '0);
        cmp("clr_pre_pass", 32'(pass), 32'd1);
        clear = 1'b1;
        start = 1'b1;
        tick();
        clear = 1'b0;
        start = 1'b0;
        check_idle_outputs("clr_done");
    endtask

    task automatic test_random();
        logic [OUT_W-1:0] model;
        logic [OUT_W-1:0] d[$];
        int               nv;
        bit               good;
        for (int r = 0; r < 8; r++) begin
            nv    = $urandom_range(1, 8);
            good  = 1'($urandom_range(0, 1));
            model = '0;
            d.delete();
            for (int i = 0; i < nv; i++) begin
                d.push_back(OUT_W'($urandom));
                model = ref_step(model, d[i]);
            end
            do_start(nv, good ? model : (model ^ 26'h0000001));
            foreach (d[i]) send(d[i], 1'b1);
            cmp("rnd_sig", 32'(signature), 32'(model));
            cmp("rnd_cnt", 32'(count), 32'(nv));
            cmp("rnd_done", 32'(done), 32'd1);
            cmp("rnd_pass", 32'(pass), 32'(good));
        end
    endtask

    initial begin
        n_vec        = 0;
        n_err        = 0;
        rst_n        = 1'b0;
        start        = 1'b0;
        clear        = 1'b0;
        num_vectors  = '0;
        expected_sig = '0;
        resp_valid   = 1'b0;
        resp_data    = '0;
        #1;
        test_reset();
        test_basic();
        test_feedback();
        test_backpressure();
        test_zero_restart();
        test_clear();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
